// File: rtl/frame_pkg.sv
// ============================================================================
// Module   : frame_pkg
// Purpose  : Shared types, palette table and FSM encoding for the frame
//            memory write/read sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_pkg;

  typedef logic [23:0] rgb_t;
  typedef logic [3:0]  pal_idx_t;

  localparam int PAL_ENTRIES = 14;

  localparam rgb_t PALETTE [0:PAL_ENTRIES-1] = '{
    24'h000000, 24'hffff00, 24'h2121ff, 24'h00ffff, 24'hff0000, 24'h00ff00, 24'h47b9ae,
    24'hf8bb55, 24'hfab9b0, 24'hfcb5ff, 24'hde9751, 24'he0ddff, 24'h000000, 24'hffffff
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/palette_encoder.sv
// ============================================================================
// Module   : palette_encoder
// Purpose  : Combinational RGB -> palette index lookup; lowest matching
//            index wins, hit=0 when the colour is not in the palette.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module palette_encoder
  import frame_pkg::*;
(
  input  rgb_t     rgb,
  output pal_idx_t idx,
  output logic     hit
);

  // Scanning downward lets the lowest matching index overwrite any higher one.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = PAL_ENTRIES - 1; i >= 0; i--) begin
      if (rgb == PALETTE[i]) begin
        idx = pal_idx_t'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sprite_frame_writer.sv
// ============================================================================
// Module   : sprite_frame_writer
// Purpose  : Rectangle-draw write side of the palette-indexed frame RAM.
//            Optional build macro: FRAME_WRITER_TRANSPARENT_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_frame_writer
  import frame_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int IDX_W      = 4,
  parameter int DIM_W      = 9,
  parameter int TRANSP_IDX = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [DIM_W-1:0]  cmd_width,
  input  logic [DIM_W-1:0]  cmd_height,
  input  logic [DIM_W-1:0]  cmd_stride,
  output logic              busy,
  output logic              done,
  output logic              miss,
  input  logic              pix_valid,
  input  logic [23:0]       pix_rgb,
  output logic              pix_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [IDX_W-1:0]  wr_data
);

`ifdef FRAME_WRITER_TRANSPARENT_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  state_t            state;
  state_t            state_nxt;
  logic [DIM_W-1:0]  width_q;
  logic [DIM_W-1:0]  height_q;
  logic [DIM_W-1:0]  stride_q;
  logic [DIM_W-1:0]  col;
  logic [DIM_W-1:0]  row;
  logic [ADDR_W-1:0] row_addr;

  pal_idx_t enc_idx;
  logic     enc_hit;
  logic     accept;
  logic     last_col;
  logic     last_row;
  logic     keep;

  palette_encoder u_enc (
    .rgb (pix_rgb),
    .idx (enc_idx),
    .hit (enc_hit)
  );

  assign accept   = pix_ready && pix_valid;
  assign last_col = (col == width_q  - DIM_W'(1));
  assign last_row = (row == height_q - DIM_W'(1));
  // Unmatched pixels always write index 0, even if 0 is the transparent index.
  assign keep     = !(TRANSP_EN && enc_hit && (enc_idx == pal_idx_t'(TRANSP_IDX)));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_start) begin
          if (cmd_width == '0 || cmd_height == '0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (accept && last_col && last_row) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    pix_ready = (state == S_RUN);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      width_q  <= '0;
      height_q <= '0;
      stride_q <= '0;
      col      <= '0;
      row      <= '0;
      row_addr <= '0;
      miss     <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (state == S_IDLE && cmd_start) begin
        width_q  <= cmd_width;
        height_q <= cmd_height;
        stride_q <= cmd_stride;
        col      <= '0;
        row      <= '0;
        row_addr <= cmd_base;
        miss     <= 1'b0;
      end else if (accept) begin
        wr_en   <= keep;
        wr_addr <= row_addr + ADDR_W'(col);
        wr_data <= IDX_W'(enc_idx);
        if (!enc_hit) begin
          miss <= 1'b1;
        end
        if (last_col) begin
          col      <= '0;
          row      <= row + DIM_W'(1);
          row_addr <= row_addr + ADDR_W'(stride_q);
        end else begin
          col <= col + DIM_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_frame_writer.sv
// ============================================================================
// Module   : tb_sprite_frame_writer
// Purpose  : Directed self-checking bench for sprite_frame_writer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_frame_writer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        cmd_start;
  logic [16:0] cmd_base;
  logic [8:0]  cmd_width;
  logic [8:0]  cmd_height;
  logic [8:0]  cmd_stride;
  logic        busy;
  logic        done;
  logic        miss;
  logic        pix_valid;
  logic [23:0] pix_rgb;
  logic        pix_ready;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [3:0]  wr_data;

  int vectors    = 0;
  int miscompares = 0;

  sprite_frame_writer dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .cmd_start  (cmd_start),
    .cmd_base   (cmd_base),
    .cmd_width  (cmd_width),
    .cmd_height (cmd_height),
    .cmd_stride (cmd_stride),
    .busy       (busy),
    .done       (done),
    .miss       (miss),
    .pix_valid  (pix_valid),
    .pix_rgb    (pix_rgb),
    .pix_ready  (pix_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr_chk(input string tag, input logic en, input logic [16:0] addr,
                        input logic [3:0] data, input logic dn);
    chk({tag, ".wr_en"}, {31'd0, wr_en}, {31'd0, en});
    if (en) begin
      chk({tag, ".wr_addr"}, {15'd0, wr_addr}, {15'd0, addr});
      chk({tag, ".wr_data"}, {28'd0, wr_data}, {28'd0, data});
    end
    chk({tag, ".done"}, {31'd0, done}, {31'd0, dn});
  endtask

  // Leaves the caller at the falling edge right after the start was sampled.
  task automatic start_cmd(input logic [16:0] base, input logic [8:0] w,
                           input logic [8:0] h, input logic [8:0] s);
    cmd_base   = base;
    cmd_width  = w;
    cmd_height = h;
    cmd_stride = s;
    cmd_start  = 1'b1;
    @(negedge Clk);
    cmd_start  = 1'b0;
  endtask

  initial begin
    Reset_n    = 1'b0;
    cmd_start  = 1'b0;
    cmd_base   = '0;
    cmd_width  = '0;
    cmd_height = '0;
    cmd_stride = '0;
    pix_valid  = 1'b0;
    pix_rgb    = '0;

    #2;
    chk("rst.busy",      {31'd0, busy},      32'd0);
    chk("rst.done",      {31'd0, done},      32'd0);
    chk("rst.miss",      {31'd0, miss},      32'd0);
    chk("rst.pix_ready", {31'd0, pix_ready}, 32'd0);
    chk("rst.wr_en",     {31'd0, wr_en},     32'd0);
    chk("rst.wr_addr",   {15'd0, wr_addr},   32'd0);
    chk("rst.wr_data",   {28'd0, wr_data},   32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // 1: 3x2 rectangle, continuous valid
    start_cmd(17'h00100, 9'd3, 9'd2, 9'd224);
    chk("t1.busy",      {31'd0, busy},      32'd1);
    chk("t1.pix_ready", {31'd0, pix_ready}, 32'd1);
    chk("t1.wr_en0",    {31'd0, wr_en},     32'd0);
    pix_valid = 1'b1;
    pix_rgb   = 24'hffff00;
    @(negedge Clk); wr_chk("t1.p0", 1'b1, 17'h00100, 4'd1, 1'b0);
    @(negedge Clk); wr_chk("t1.p1", 1'b1, 17'h00101, 4'd1, 1'b0);
    @(negedge Clk); wr_chk("t1.p2", 1'b1, 17'h00102, 4'd1, 1'b0);
    @(negedge Clk); wr_chk("t1.p3", 1'b1, 17'h001E0, 4'd1, 1'b0);
    @(negedge Clk); wr_chk("t1.p4", 1'b1, 17'h001E1, 4'd1, 1'b0);
    @(negedge Clk); wr_chk("t1.p5", 1'b1, 17'h001E2, 4'd1, 1'b1);
    chk("t1.pix_ready_done", {31'd0, pix_ready}, 32'd0);
    pix_valid = 1'b0;
    @(negedge Clk);
    wr_chk("t1.idle", 1'b0, 17'h0, 4'h0, 1'b0);
    chk("t1.busy_idle", {31'd0, busy}, 32'd0);

    // 2: valid gap stalls the counters
    start_cmd(17'h00200, 9'd2, 9'd1, 9'd0);
    pix_valid = 1'b1;
    pix_rgb   = 24'h2121ff;
    @(negedge Clk); wr_chk("t2.p0", 1'b1, 17'h00200, 4'd2, 1'b0);
    pix_valid = 1'b0;
    pix_rgb   = 24'hffffff;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); wr_chk("t2.gap", 1'b0, 17'h0, 4'h0, 1'b0);
    end
    pix_valid = 1'b1;
    @(negedge Clk); wr_chk("t2.p1", 1'b1, 17'h00201, 4'd13, 1'b1);
    chk("t2.miss", {31'd0, miss}, 32'd0);
    pix_valid = 1'b0;
    @(negedge Clk);

    // 3: colour not in palette
    start_cmd(17'h00010, 9'd1, 9'd1, 9'd0);
    pix_valid = 1'b1;
    pix_rgb   = 24'h123456;
    @(negedge Clk); wr_chk("t3.p0", 1'b1, 17'h00010, 4'd0, 1'b1);
    chk("t3.miss", {31'd0, miss}, 32'd1);
    pix_valid = 1'b0;
    @(negedge Clk);
    chk("t3.miss_after", {31'd0, miss}, 32'd1);

    // 4: address wrap; the start also clears miss
    start_cmd(17'h1FFFF, 9'd2, 9'd1, 9'd0);
    chk("t4.miss_clr", {31'd0, miss}, 32'd0);
    pix_valid = 1'b1;
    pix_rgb   = 24'hffff00;
    @(negedge Clk); wr_chk("t4.p0", 1'b1, 17'h1FFFF, 4'd1, 1'b0);
    @(negedge Clk); wr_chk("t4.p1", 1'b1, 17'h00000, 4'd1, 1'b1);
    pix_valid = 1'b0;
    @(negedge Clk);

    // 5: zero-width command; start held through DONE must be ignored
    cmd_width  = 9'd0;
    cmd_height = 9'd5;
    cmd_start  = 1'b1;
    @(negedge Clk);
    wr_chk("t5.done", 1'b0, 17'h0, 4'h0, 1'b1);
    chk("t5.busy", {31'd0, busy}, 32'd1);
    cmd_width  = 9'd3;
    cmd_height = 9'd1;
    @(negedge Clk);
    cmd_start = 1'b0;
    wr_chk("t5.after", 1'b0, 17'h0, 4'h0, 1'b0);
    chk("t5.busy_after", {31'd0, busy}, 32'd0);
    @(negedge Clk);
    chk("t5.still_idle", {31'd0, busy}, 32'd0);

    // 6: reset mid-row
    start_cmd(17'h00300, 9'd4, 9'd1, 9'd0);
    pix_valid = 1'b1;
    pix_rgb   = 24'hffff00;
    @(negedge Clk); wr_chk("t6.p0", 1'b1, 17'h00300, 4'd1, 1'b0);
    @(negedge Clk); wr_chk("t6.p1", 1'b1, 17'h00301, 4'd1, 1'b0);
    Reset_n = 1'b0;
    #1;
    chk("t6.wr_en",     {31'd0, wr_en},     32'd0);
    chk("t6.busy",      {31'd0, busy},      32'd0);
    chk("t6.pix_ready", {31'd0, pix_ready}, 32'd0);
    chk("t6.wr_addr",   {15'd0, wr_addr},   32'd0);
    chk("t6.wr_data",   {28'd0, wr_data},   32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      wr_chk("t6.post", 1'b0, 17'h0, 4'h0, 1'b0);
      chk("t6.post_busy", {31'd0, busy}, 32'd0);
    end
    pix_valid = 1'b0;
    @(negedge Clk);

    // 7: transparent index handling
    start_cmd(17'h00400, 9'd2, 9'd1, 9'd0);
    pix_valid = 1'b1;
    pix_rgb   = 24'h000000;
    @(negedge Clk);
`ifdef FRAME_WRITER_TRANSPARENT_EN
    wr_chk("t7.p0", 1'b0, 17'h0, 4'h0, 1'b0);
`else
    wr_chk("t7.p0", 1'b1, 17'h00400, 4'd0, 1'b0);
`endif
    pix_rgb = 24'hff0000;
    @(negedge Clk); wr_chk("t7.p1", 1'b1, 17'h00401, 4'd4, 1'b1);
    chk("t7.miss", {31'd0, miss}, 32'd0);
    pix_valid = 1'b0;
    @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
